// File: rtl/rand_walk_placer.sv
// Random-walk placer: maps graph nodes onto a GRID_W x GRID_H PE grid, then sums wiring cost.
// Define PLACER_EVAL_1HOP_EN to build the 1-hop cost accumulator; otherwise cost_1hop reads 0.
module rand_walk_placer #(
    parameter int          GRID_W    = 11,
    parameter int          GRID_H    = 11,
    parameter int          N_NODES   = 16,
    parameter int          N_EDGES   = 125,
    parameter int          MAX_TRIES = 64,
    parameter logic [31:0] SEED      = 32'h1D872B41,
    localparam int         EAW       = (N_EDGES > 0) ? $clog2(N_EDGES + 1) : 1,
    localparam int         NW        = $clog2(N_NODES)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           edge_rd,
    output logic [EAW-1:0] edge_addr,
    input  logic [NW-1:0]  edge_a,
    input  logic [NW-1:0]  edge_b,
    output logic           busy,
    output logic           done,
    output logic           fail,
    output logic [31:0]    cost,
    output logic [31:0]    cost_1hop,
    output logic [3:0]     dbg_state
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT_E, S_CHECK, S_SEED_A, S_NEAR, S_TEST, S_COMMIT,
        S_EVAL_FETCH, S_EVAL_WAIT, S_EVAL_ACC, S_DONE
    } state_t;

    localparam int          NCELL   = GRID_W * GRID_H;
    localparam int          CIW     = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int          TW      = $clog2(MAX_TRIES + 1);
    localparam int          RMAX    = (GRID_W > GRID_H) ? GRID_W : GRID_H;
    localparam logic [31:0] TAPS    = 32'h80200003;
    localparam logic [31:0] SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;

    state_t             state_q, state_d;
    logic [31:0]        lfsr_q;
    logic [EAW-1:0]     e_q, e_d;
    logic [NW-1:0]      a_q, b_q, tgt_q, tgt_d, anc_q, anc_d;
    logic [TW-1:0]      tries_q, tries_d;
    logic signed [15:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic               near_zero_q, near_zero_d;
    logic               from_seed_q, from_seed_d;
    logic               fail_q, fail_d;
    logic [31:0]        cost_q;
    logic signed [15:0] pos_x_q [N_NODES];
    logic signed [15:0] pos_y_q [N_NODES];
    logic [N_NODES-1:0] placed_q;
    logic [NCELL-1:0]   occ_q;

    logic               accept, clear, acc_en;
    logic [15:0]        radius, span, mod_x, mod_y, seed_x, seed_y;
    logic signed [15:0] dx_n, dy_n;
    logic               oob, occ_hit, reject;
    logic [31:0]        cell_idx;
    int                 ex, ey, ax, ay, man_term;

    assign accept = (state_q == S_IDLE) && start;
    assign clear  = reset || accept;

    // Candidate generation and test arithmetic
    always_comb begin
        radius = 16'(1 + (int'(tries_q) >> 2));
        if (int'(radius) > RMAX) radius = 16'(RMAX);
        span   = (radius << 1) + 16'd1;
        mod_x  = {8'd0, lfsr_q[7:0]} % span;
        mod_y  = {8'd0, lfsr_q[15:8]} % span;
        dx_n   = $signed(mod_x) - $signed(radius);
        dy_n   = $signed(mod_y) - $signed(radius);
        seed_x = 16'(32'(lfsr_q[15:0]) % 32'(GRID_W));
        seed_y = 16'(32'(lfsr_q[31:16]) % 32'(GRID_H));
        oob      = (cand_x_q < 16'sd0) || (int'(cand_x_q) >= GRID_W) ||
                   (cand_y_q < 16'sd0) || (int'(cand_y_q) >= GRID_H);
        cell_idx = 32'(int'(cand_y_q) * GRID_W + int'(cand_x_q));
        occ_hit  = 1'b0;
        if (!oob) occ_hit = occ_q[cell_idx[CIW-1:0]];
        reject   = oob || near_zero_q || occ_hit;
        ex       = int'(pos_x_q[a_q]) - int'(pos_x_q[b_q]);
        ey       = int'(pos_y_q[a_q]) - int'(pos_y_q[b_q]);
        ax       = (ex < 0) ? -ex : ex;
        ay       = (ey < 0) ? -ey : ey;
        man_term = ax + ay - 1;
    end

    assign acc_en = (state_q == S_EVAL_ACC) && (a_q != b_q) && placed_q[a_q] && placed_q[b_q];

    // Edge port: edge_rd is a one-cycle strobe for edge_addr; edge_a/edge_b are sampled the cycle after.
    always_comb begin
        state_d     = state_q;
        e_d         = e_q;
        tgt_d       = tgt_q;
        anc_d       = anc_q;
        tries_d     = tries_q;
        cand_x_d    = cand_x_q;
        cand_y_d    = cand_y_q;
        near_zero_d = near_zero_q;
        from_seed_d = from_seed_q;
        fail_d      = fail_q;
        edge_rd     = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_FETCH;
                e_d     = '0;
                tries_d = '0;
                fail_d  = 1'b0;
            end
            S_FETCH: if (int'(e_q) == N_EDGES) begin
                state_d = S_EVAL_FETCH;
                e_d     = '0;
            end else begin
                edge_rd = 1'b1;
                state_d = S_WAIT_E;
            end
            S_WAIT_E: state_d = S_CHECK;
            S_CHECK: if ((a_q == b_q) || (placed_q[a_q] && placed_q[b_q])) begin
                e_d     = e_q + 1'b1;
                state_d = S_FETCH;
            end else if (!placed_q[a_q] && !placed_q[b_q]) begin
                tgt_d   = a_q;
                anc_d   = b_q;
                state_d = S_SEED_A;
            end else if (placed_q[a_q]) begin
                tgt_d   = b_q;
                anc_d   = a_q;
                state_d = S_NEAR;
            end else begin
                tgt_d   = a_q;
                anc_d   = b_q;
                state_d = S_NEAR;
            end
            S_SEED_A: begin
                cand_x_d    = $signed(seed_x);
                cand_y_d    = $signed(seed_y);
                near_zero_d = 1'b0;
                from_seed_d = 1'b1;
                state_d     = S_TEST;
            end
            S_NEAR: begin
                cand_x_d    = pos_x_q[anc_q] + dx_n;
                cand_y_d    = pos_y_q[anc_q] + dy_n;
                near_zero_d = (dx_n == 16'sd0) && (dy_n == 16'sd0);
                from_seed_d = 1'b0;
                state_d     = S_TEST;
            end
            S_TEST: if (reject) begin
                tries_d = tries_q + 1'b1;
                if (tries_q == TW'(MAX_TRIES - 1)) begin
                    fail_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = from_seed_q ? S_SEED_A : S_NEAR;
                end
            end else begin
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                tries_d = '0;
                if (from_seed_q) begin
                    tgt_d   = b_q;
                    anc_d   = a_q;
                    state_d = S_NEAR;
                end else begin
                    e_d     = e_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EVAL_FETCH: if (int'(e_q) == N_EDGES) begin
                state_d = S_DONE;
            end else begin
                edge_rd = 1'b1;
                state_d = S_EVAL_WAIT;
            end
            S_EVAL_WAIT: state_d = S_EVAL_ACC;
            S_EVAL_ACC: begin
                e_d     = e_q + 1'b1;
                state_d = S_EVAL_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            e_q         <= '0;
            tgt_q       <= '0;
            anc_q       <= '0;
            tries_q     <= '0;
            cand_x_q    <= '0;
            cand_y_q    <= '0;
            near_zero_q <= 1'b0;
            from_seed_q <= 1'b0;
            fail_q      <= 1'b0;
            lfsr_q      <= SEED_NZ;
        end else begin
            state_q     <= state_d;
            e_q         <= e_d;
            tgt_q       <= tgt_d;
            anc_q       <= anc_d;
            tries_q     <= tries_d;
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            near_zero_q <= near_zero_d;
            from_seed_q <= from_seed_d;
            fail_q      <= fail_d;
            if (state_q != S_IDLE) lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if ((state_q == S_WAIT_E) || (state_q == S_EVAL_WAIT)) begin
            a_q <= edge_a;
            b_q <= edge_b;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            placed_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < N_NODES; i++) begin
                pos_x_q[i] <= '0;
                pos_y_q[i] <= '0;
            end
        end else if (state_q == S_COMMIT) begin
            pos_x_q[tgt_q]              <= cand_x_q;
            pos_y_q[tgt_q]              <= cand_y_q;
            placed_q[tgt_q]             <= 1'b1;
            occ_q[cell_idx[CIW-1:0]]    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) cost_q <= '0;
        else if (acc_en) cost_q <= cost_q + 32'(man_term);
    end

`ifdef PLACER_EVAL_1HOP_EN
    logic [31:0] hop_q;
    int          hop_term;
    assign hop_term = ((ax + 1) >>> 1) + ((ay + 1) >>> 1) - 1;
    always_ff @(posedge clk) begin
        if (clear) hop_q <= '0;
        else if (acc_en) hop_q <= hop_q + 32'(hop_term);
    end
    assign cost_1hop = hop_q;
`else
    assign cost_1hop = 32'd0;
`endif

    assign edge_addr = e_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign fail      = fail_q;
    assign cost      = cost_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_rand_walk_placer.sv
// Bench for rand_walk_placer: five parameterisations, a behavioural placement model and an expected queue.
module tb_rand_walk_placer;
  localparam int EXPW = 81;
  localparam logic [31:0] SEED = 32'h1D872B41;
  localparam logic [3:0] ST_NEAR = 4'd5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] start_r = '0;
  int n_vec = 0;
  int n_err = 0;
  int rom_a [5][128];
  int rom_b [5][128];
  logic [EXPW-1:0] exp_q[$];

  wire [4:0] rd_w, busy_w, done_w, fail_w;
  wire [31:0] cost_w [5];
  wire [31:0] hop_w [5];
  wire [3:0] dbg_w [5];
  wire [0:0] addr0, addr1, addr2;
  wire [1:0] addr3;
  wire [6:0] addr4;
  logic [0:0] ea1, eb1, ea2, eb2;
  logic [3:0] ea3, eb3, ea4, eb4;

  always #5 clk = ~clk;

  rand_walk_placer #(.N_EDGES(0)) u0 (
    .clk(clk), .reset(reset), .start(start_r[0]), .edge_rd(rd_w[0]), .edge_addr(addr0),
    .edge_a(4'd0), .edge_b(4'd0), .busy(busy_w[0]), .done(done_w[0]), .fail(fail_w[0]),
    .cost(cost_w[0]), .cost_1hop(hop_w[0]), .dbg_state(dbg_w[0]));
  rand_walk_placer #(.GRID_W(2), .GRID_H(1), .N_NODES(2), .N_EDGES(1)) u1 (
    .clk(clk), .reset(reset), .start(start_r[1]), .edge_rd(rd_w[1]), .edge_addr(addr1),
    .edge_a(ea1), .edge_b(eb1), .busy(busy_w[1]), .done(done_w[1]), .fail(fail_w[1]),
    .cost(cost_w[1]), .cost_1hop(hop_w[1]), .dbg_state(dbg_w[1]));
  rand_walk_placer #(.GRID_W(1), .GRID_H(1), .N_NODES(2), .N_EDGES(1), .MAX_TRIES(8)) u2 (
    .clk(clk), .reset(reset), .start(start_r[2]), .edge_rd(rd_w[2]), .edge_addr(addr2),
    .edge_a(ea2), .edge_b(eb2), .busy(busy_w[2]), .done(done_w[2]), .fail(fail_w[2]),
    .cost(cost_w[2]), .cost_1hop(hop_w[2]), .dbg_state(dbg_w[2]));
  rand_walk_placer #(.N_EDGES(3)) u3 (
    .clk(clk), .reset(reset), .start(start_r[3]), .edge_rd(rd_w[3]), .edge_addr(addr3),
    .edge_a(ea3), .edge_b(eb3), .busy(busy_w[3]), .done(done_w[3]), .fail(fail_w[3]),
    .cost(cost_w[3]), .cost_1hop(hop_w[3]), .dbg_state(dbg_w[3]));
  rand_walk_placer u4 (
    .clk(clk), .reset(reset), .start(start_r[4]), .edge_rd(rd_w[4]), .edge_addr(addr4),
    .edge_a(ea4), .edge_b(eb4), .busy(busy_w[4]), .done(done_w[4]), .fail(fail_w[4]),
    .cost(cost_w[4]), .cost_1hop(hop_w[4]), .dbg_state(dbg_w[4]));

  // Edge-list ROMs with one cycle of read latency
  always @(posedge clk) begin
    if (rd_w[1]) begin ea1 <= 1'(rom_a[1][addr1]); eb1 <= 1'(rom_b[1][addr1]); end
    if (rd_w[2]) begin ea2 <= 1'(rom_a[2][addr2]); eb2 <= 1'(rom_b[2][addr2]); end
    if (rd_w[3]) begin ea3 <= 4'(rom_a[3][addr3]); eb3 <= 4'(rom_b[3][addr3]); end
    if (rd_w[4]) begin ea4 <= 4'(rom_a[4][addr4]); eb4 <= 4'(rom_b[4][addr4]); end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model of one run from a fresh LFSR: returns {latency, fail, cost, cost_1hop}
  task automatic model_run(input int k, input int gw, input int gh, input int ne, input int mt,
                           output logic [EXPW-1:0] res);
    logic [31:0] lf;
    int px[16], py[16];
    bit pl[16];
    bit oc[256];
    int cyc, a, b, tgt, anc, tries, cx, cy, dx, dy, r, rmax, s, cost, hop, ax, ay;
    bit failf, ok;
    foreach (px[i]) begin px[i] = 0; py[i] = 0; pl[i] = 0; end
    foreach (oc[i]) oc[i] = 0;
    lf = SEED; cyc = 0; failf = 0; cost = 0; hop = 0; tgt = 0; anc = 0; cx = 0; cy = 0;
    rmax = (gw > gh) ? gw : gh;
    for (int e = 0; e < ne && !failf; e++) begin
      for (int i = 0; i < 3; i++) begin lf = lfsr_step(lf); cyc++; end
      a = rom_a[k][e]; b = rom_b[k][e];
      if (a == b || (pl[a] && pl[b])) continue;
      if (!pl[a] && !pl[b]) begin
        tries = 0; ok = 0;
        while (!ok && !failf) begin
          cx = int'(lf[15:0]) % gw; cy = int'(lf[31:16]) % gh;
          for (int i = 0; i < 2; i++) begin lf = lfsr_step(lf); cyc++; end
          ok = !oc[cy * gw + cx];
          if (!ok) begin tries++; if (tries == mt) failf = 1; end
        end
        if (failf) break;
        px[a] = cx; py[a] = cy; pl[a] = 1; oc[cy * gw + cx] = 1;
        lf = lfsr_step(lf); cyc++;
        tgt = b; anc = a;
      end else if (pl[a]) begin
        tgt = b; anc = a;
      end else begin
        tgt = a; anc = b;
      end
      tries = 0; ok = 0;
      while (!ok && !failf) begin
        r = 1 + tries / 4;
        if (r > rmax) r = rmax;
        s = 2 * r + 1;
        dx = int'(lf[7:0]) % s - r; dy = int'(lf[15:8]) % s - r;
        cx = px[anc] + dx; cy = py[anc] + dy;
        for (int i = 0; i < 2; i++) begin lf = lfsr_step(lf); cyc++; end
        ok = cx >= 0 && cx < gw && cy >= 0 && cy < gh && !(dx == 0 && dy == 0) && !oc[cy * gw + cx];
        if (!ok) begin tries++; if (tries == mt) failf = 1; end
      end
      if (failf) break;
      px[tgt] = cx; py[tgt] = cy; pl[tgt] = 1; oc[cy * gw + cx] = 1;
      lf = lfsr_step(lf); cyc++;
    end
    if (!failf) begin
      cyc++;
      for (int e = 0; e < ne; e++) begin
        cyc += 3;
        a = rom_a[k][e]; b = rom_b[k][e];
        if (a != b && pl[a] && pl[b]) begin
          ax = px[a] - px[b]; if (ax < 0) ax = -ax;
          ay = py[a] - py[b]; if (ay < 0) ay = -ay;
          cost += ax + ay - 1;
          hop += (ax + 1) / 2 + (ay + 1) / 2 - 1;
        end
      end
      cyc++;
    end
`ifndef PLACER_EVAL_1HOP_EN
    hop = 0;
`endif
    res = {16'(cyc + 1), failf, 32'(cost), 32'(hop)};
  endtask

  task automatic run_and_check(input int k, input int gw, input int gh, input int ne, input int mt,
                               input bit poke, input string tag);
    logic [EXPW-1:0] res, exp;
    int lat, extra;
    model_run(k, gw, gh, ne, mt, res);
    exp_q.push_back(res);
    @(negedge clk); start_r[k] = 1'b1;
    @(negedge clk); start_r[k] = 1'b0; lat = 1;
    while (!done_w[k] && lat < 20000) begin
      start_r[k] = poke && (lat == 12);
      @(negedge clk); lat++;
    end
    start_r[k] = 1'b0;
    exp = exp_q.pop_front();
    check({tag, " done_seen"}, 64'(done_w[k]), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp[80:65]));
    check({tag, " fail"}, 64'(fail_w[k]), 64'(exp[64]));
    check({tag, " cost"}, 64'(cost_w[k]), 64'(exp[63:32]));
    check({tag, " cost_1hop"}, 64'(hop_w[k]), 64'(exp[31:0]));
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_w[k]) extra++;
    end
    check({tag, " done_once"}, 64'(extra), 64'd0);
    check({tag, " busy_after"}, 64'(busy_w[k]), 64'd0);
    check({tag, " cost_held"}, 64'(cost_w[k]), 64'(exp[63:32]));
    check({tag, " fail_held"}, 64'(fail_w[k]), 64'(exp[64]));
  endtask

  initial begin
    int w;
    rom_a[1][0] = 0; rom_b[1][0] = 1;
    rom_a[2][0] = 0; rom_b[2][0] = 1;
    rom_a[3][0] = 0; rom_b[3][0] = 0;
    rom_a[3][1] = 2; rom_b[3][1] = 3;
    rom_a[3][2] = 3; rom_b[3][2] = 2;
    for (int e = 0; e < 125; e++) begin
      rom_a[4][e] = int'($urandom_range(0, 15));
      rom_b[4][e] = int'($urandom_range(0, 15));
    end

    // clock/reset
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy_w[4]), 64'd0);
    check("rst done", 64'(done_w[4]), 64'd0);
    check("rst fail", 64'(fail_w[4]), 64'd0);
    check("rst cost", 64'(cost_w[4]), 64'd0);
    check("rst cost_1hop", 64'(hop_w[4]), 64'd0);
    check("rst edge_rd", 64'(rd_w[4]), 64'd0);
    check("rst edge_addr", 64'(addr4), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_and_check(0, 11, 11, 0, 64, 1'b0, "no_edges");
    run_and_check(1, 2, 1, 1, 64, 1'b0, "grid2x1");
    run_and_check(2, 1, 1, 1, 8, 1'b0, "grid1x1");
    check("grid1x1 fail_const", 64'(fail_w[2]), 64'd1);
    run_and_check(3, 11, 11, 3, 64, 1'b1, "three_edges");
    run_and_check(4, 11, 11, 125, 64, 1'b0, "random125");

    // interrupted run: reset while in NEAR
    @(negedge clk); start_r[4] = 1'b1;
    @(negedge clk); start_r[4] = 1'b0;
    w = 0;
    while (dbg_w[4] != ST_NEAR && w < 5000) begin @(negedge clk); w++; end
    check("midrun reached_near", 64'(dbg_w[4]), 64'(ST_NEAR));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrun busy", 64'(busy_w[4]), 64'd0);
    check("midrun done", 64'(done_w[4]), 64'd0);
    check("midrun fail", 64'(fail_w[4]), 64'd0);
    check("midrun cost", 64'(cost_w[4]), 64'd0);
    check("midrun cost_1hop", 64'(hop_w[4]), 64'd0);
    check("midrun edge_rd", 64'(rd_w[4]), 64'd0);
    check("midrun edge_addr", 64'(addr4), 64'd0);
    run_and_check(4, 11, 11, 125, 64, 1'b0, "rerun_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
